// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard-controller bundle between the pipeline stages and pipeline_ctrl
// Inputs to the controller: D-stage operands (d_valid, d_rs1, d_rs2), E-stage producer info
// (e_rd, e_write_reg, e_info_load, e_redirect) and M-stage memory handshake (m_mem_req, m_mem_ack).
// Outputs from the controller: stall_f/d/e, flush_fd/de, state and the saturating stall_cnt/redir_cnt.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  logic d_valid;
  logic [4:0] d_rs1, d_rs2, e_rd;
  logic e_write_reg;
  logic [2:0] e_info_load;
  logic e_redirect, m_mem_req, m_mem_ack;
  logic stall_f, stall_d, stall_e, flush_fd, flush_de;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
  modport master (
    output d_valid, d_rs1, d_rs2, e_rd, e_write_reg, e_info_load, e_redirect, m_mem_req, m_mem_ack,
    input stall_f, stall_d, stall_e, flush_fd, flush_de, state, stall_cnt, redir_cnt
  );
  modport slave (
    input d_valid, d_rs1, d_rs2, e_rd, e_write_reg, e_info_load, e_redirect, m_mem_req, m_mem_ack,
    output stall_f, stall_d, stall_e, flush_fd, flush_de, state, stall_cnt, redir_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencing for load-use, E-stage redirects and M-stage memory waits
// Ports: clk, rst (sync, active-high), p (pipeline_ctrl_if.slave) carrying the stage hazard inputs,
// stall/flush controls, state (0=RUN 1=MEM_WAIT 2=REDIRECT) and saturating stall/redirect counters.
module pipeline_ctrl #(
  parameter logic [2:0] NOTLOAD_CODE = 3'b111,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.slave p
);
  localparam int RW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;
  state_t st, st_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [CNT_W-1:0] sc, rc;
  logic load_use, mem_wait, stall, stall_e, flush, redir_acc, lu_bubble;
  assign load_use = p.d_valid & p.e_write_reg & (p.e_info_load != NOTLOAD_CODE) & (p.e_rd != 5'd0) &
                    ((p.e_rd == p.d_rs1) | (p.e_rd == p.d_rs2));
  assign mem_wait = p.m_mem_req & ~p.m_mem_ack;
  always_comb begin
    st_n = st;
    rcnt_n = rcnt;
    stall = 1'b0;
    stall_e = 1'b0;
    flush = 1'b0;
    lu_bubble = 1'b0;
    redir_acc = 1'b0;
    if (rst) begin
      flush = 1'b1;
    end else begin
      case (st)
        RUN:
          if (mem_wait) begin
            stall = 1'b1;
            stall_e = 1'b1;
            st_n = MEM_WAIT;
          end else if (p.e_redirect) begin
            flush = 1'b1;
            redir_acc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              rcnt_n = RW'(FLUSH_CYCLES - 1);
              st_n = REDIRECT;
            end
          end else if (load_use) begin
            stall = 1'b1;
            lu_bubble = 1'b1;
          end
        MEM_WAIT: begin
          stall = ~p.m_mem_ack;
          stall_e = ~p.m_mem_ack;
          if (p.m_mem_ack) st_n = (rcnt != '0) ? REDIRECT : RUN;
        end
        REDIRECT:
          if (mem_wait) begin
            stall = 1'b1;
            stall_e = 1'b1;
            st_n = MEM_WAIT;
          end else begin
            flush = 1'b1;
            rcnt_n = rcnt - RW'(1);
            if (rcnt == RW'(1)) st_n = RUN;
          end
        default: st_n = RUN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      rcnt <= '0;
      sc <= '0;
      rc <= '0;
    end else begin
      st <= st_n;
      rcnt <= rcnt_n;
      if (stall && !(&sc)) sc <= sc + 1'b1;
      if (redir_acc && !(&rc)) rc <= rc + 1'b1;
    end
  end
  assign p.stall_f = stall;
  assign p.stall_d = stall;
  assign p.stall_e = stall_e;
  assign p.flush_fd = flush;
  assign p.flush_de = flush | lu_bubble;
  assign p.state = st;
  assign p.stall_cnt = sc;
  assign p.redir_cnt = rc;
endmodule
